// File: rtl/spi_adc_slave.sv
// SPI mode-0 responder: streams the latest ADC sample out on MISO and collects the
// master's command word from MOSI, with all SPI pins oversampled on CLK_IN.
//
// state  | meaning
// IDLE   | SS high (or not yet armed); MISO driven low, waiting for SS to fall
// ACTIVE | frame in progress; shift MISO on SCLK fall, capture MOSI on SCLK rise
module spi_adc_slave #(
  parameter int DATA_W      = 12,
  parameter int FRAME_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK_IN,
  input  logic               XRES_IN,
  input  logic               SCLK,
  input  logic               SS,
  input  logic               MOSI,
  output logic               MISO,
  input  logic [DATA_W-1:0]  sample_in,
  input  logic               sample_valid,
  output logic [FRAME_W-1:0] cmd_data,
  output logic               cmd_valid,
  output logic               frame_err,
  output logic               busy
);

  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_q, ss_q, mosi_q;
  logic                    sclk_d, ss_d;
  logic [SYNC_STAGES:0]    fill;
  logic                    armed;
  logic [DATA_W-1:0]       hold;
  logic [FRAME_W-1:0]      tx_sr, rx_sr;
  logic [CNT_W-1:0]        bit_cnt;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise, ready;
  logic [FRAME_W-1:0] snap_word;

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign ss_s      = ss_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ready     = fill[SYNC_STAGES];
  assign snap_word = FRAME_W'(sample_valid ? sample_in : hold);

  always_ff @(posedge CLK_IN or negedge XRES_IN) begin
    if (!XRES_IN) begin
      sclk_q <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      ss_d   <= 1'b1;
      fill   <= '0;
      armed  <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], SCLK};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], SS};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
      sclk_d <= sclk_s;
      ss_d   <= ss_s;
      fill   <= {fill[SYNC_STAGES-1:0], 1'b1};
      // A frame already running at reset release is ignored until SS is seen high
      if (ready && ss_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge CLK_IN or negedge XRES_IN) begin
    if (!XRES_IN) hold <= '0;
    else if (sample_valid) hold <= sample_in;
  end

  always_ff @(posedge CLK_IN or negedge XRES_IN) begin
    if (!XRES_IN) begin
      state     <= IDLE;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      MISO      <= 1'b0;
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          MISO <= 1'b0;
          busy <= 1'b0;
          if (ss_fall && armed) begin
            tx_sr   <= snap_word;
            rx_sr   <= '0;
            bit_cnt <= '0;
            MISO    <= snap_word[FRAME_W-1];
            busy    <= 1'b1;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          busy <= 1'b1;
          if (ss_rise) begin
            state <= IDLE;
            MISO  <= 1'b0;
            busy  <= 1'b0;
            if (bit_cnt == CNT_FULL) begin
              cmd_data  <= rx_sr;
              cmd_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            rx_sr <= {mosi_s, rx_sr[FRAME_W-1:1]};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
          end else if (sclk_fall) begin
            // zero fill keeps MISO low once the word is exhausted
            tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
            MISO  <= tx_sr[FRAME_W-2];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
